// File: rtl/csla_pkg.sv
// csla_pkg: shared constants and elaboration helpers for the pipelined carry-select adder.
// Optional overflow output is enabled with the CSLA_PIPE_OVF_EN macro (see csla_pipe).
package csla_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Ceiling divide used to derive the stage count from the group count
  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
    return (n + d - 1) / d;
  endfunction

  // Legal geometry: whole number of groups and at least one group per stage
  function automatic bit cfg_ok(input int unsigned width, input int unsigned block,
                                input int unsigned gps);
    return (block != 0) && (width >= block) && ((width % block) == 0) && (gps >= 1);
  endfunction

endpackage

// File: rtl/csla_pipe_if.sv
// csla_pipe_if: operand/result valid-ready bundle for csla_pipe.
// The ovf signal exists only when CSLA_PIPE_OVF_EN is defined.
interface csla_pipe_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CSLA_PIPE_OVF_EN
  logic             ovf;

  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
`else
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout);
`endif

endinterface

// File: rtl/csla_group.sv
// csla_group: one carry-select group; two ripple rows (carry-in 0 and 1) and a final mux.
module csla_group #(
  parameter int unsigned BLOCK = 4
) (
  input  logic [BLOCK-1:0] i_a,
  input  logic [BLOCK-1:0] i_b,
  input  logic             i_ci,
  output logic [BLOCK-1:0] o_s,
  output logic             o_co
);

  logic [BLOCK-1:0] w_s0;
  logic [BLOCK-1:0] w_s1;
  logic [BLOCK:0]   w_c0;
  logic [BLOCK:0]   w_c1;

  // Both ripple rows are evaluated unconditionally so only the mux waits on i_ci
  always_comb begin
    w_s0    = '0;
    w_s1    = '0;
    w_c0    = '0;
    w_c1    = '0;
    w_c1[0] = 1'b1;
    for (int unsigned i = 0; i < BLOCK; i++) begin
      w_s0[i]   = i_a[i] ^ i_b[i] ^ w_c0[i];
      w_c0[i+1] = (i_a[i] & i_b[i]) | (w_c0[i] & (i_a[i] ^ i_b[i]));
      w_s1[i]   = i_a[i] ^ i_b[i] ^ w_c1[i];
      w_c1[i+1] = (i_a[i] & i_b[i]) | (w_c1[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_s  = i_ci ? w_s1 : w_s0;
  assign o_co = i_ci ? w_c1[BLOCK] : w_c0[BLOCK];

endmodule

// File: rtl/csla_pipe.sv
// csla_pipe: pipelined carry-select adder/subtractor with valid/ready flow control.
// Each stage resolves GPS groups using the carry registered by the previous stage.
// Define CSLA_PIPE_OVF_EN to add the pipelined signed-overflow output (bus.ovf).
module csla_pipe
  import csla_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLOCK = 4,
  parameter int unsigned GPS   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  csla_pipe_if.slave    bus
);

  localparam int unsigned NG = WIDTH / BLOCK;
  localparam int unsigned NS = ceil_div(NG, GPS);

  if (!cfg_ok(WIDTH, BLOCK, GPS)) begin : g_cfg_err
    $error("csla_pipe: WIDTH must be a non-zero multiple of BLOCK and GPS must be >= 1");
  end

  // Stage registers; operand copies travel with the op, consumed low bits are never read
  logic [WIDTH-1:0] r_a   [NS];
  logic [WIDTH-1:0] r_b   [NS];
  logic [WIDTH-1:0] r_sum [NS];
  logic [NS-1:0]    r_c;
  logic [NS-1:0]    r_v;

  // Per-stage inputs (from the bus for stage 0, else from the previous stage)
  logic [WIDTH-1:0] w_a    [NS];
  logic [WIDTH-1:0] w_b    [NS];
  logic [WIDTH-1:0] w_sin  [NS];
  logic [WIDTH-1:0] w_snext[NS];
  logic [NS-1:0]    w_ci;
  logic [NS-1:0]    w_vin;
  logic [NS-1:0]    w_cnext;
  logic [NS-1:0]    w_load;

  logic [BLOCK-1:0] w_gs  [NG];
  logic             w_gco [NG];

  // Stage inputs; subtract inverts B and forces the carry-in to 1
  always_comb begin
    w_ci     = '0;
    w_vin    = '0;
    w_a[0]   = bus.a;
    w_b[0]   = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
    w_ci[0]  = (bus.sub == OP_SUB) ? 1'b1 : bus.cin;
    w_sin[0] = '0;
    w_vin[0] = bus.in_valid;
    for (int unsigned s = 1; s < NS; s++) begin
      w_a[s]   = r_a[s-1];
      w_b[s]   = r_b[s-1];
      w_ci[s]  = r_c[s-1];
      w_sin[s] = r_sum[s-1];
      w_vin[s] = r_v[s-1];
    end
  end

  // Group array; the first group of a stage takes that stage's registered carry
  for (genvar g = 0; g < NG; g++) begin : g_grp
    localparam int unsigned STG = g / GPS;
    logic w_ci_l;
    logic w_co_l;

    if ((g % GPS) == 0) begin : g_head
      assign w_ci_l = w_ci[STG];
    end else begin : g_link
      assign w_ci_l = g_grp[g-1].w_co_l;
    end

    csla_group #(.BLOCK(BLOCK)) u_grp (
      .i_a  (w_a[STG][g*BLOCK +: BLOCK]),
      .i_b  (w_b[STG][g*BLOCK +: BLOCK]),
      .i_ci (w_ci_l),
      .o_s  (w_gs[g]),
      .o_co (w_co_l)
    );

    assign w_gco[g] = w_co_l;
  end

  // Merge each stage's resolved groups into its partial sum and pick its outgoing carry
  always_comb begin
    w_cnext = '0;
    for (int unsigned s = 0; s < NS; s++) begin
      w_snext[s] = w_sin[s];
    end
    for (int unsigned g = 0; g < NG; g++) begin
      w_snext[g/GPS][g*BLOCK +: BLOCK] = w_gs[g];
      w_cnext[g/GPS]                   = w_gco[g];
    end
  end

  // Load enables ripple back from the output so bubbles collapse under stall
  always_comb begin
    w_load         = '0;
    w_load[NS-1]   = !r_v[NS-1] || bus.out_ready;
    for (int s = int'(NS) - 2; s >= 0; s--) begin
      w_load[s] = !r_v[s] || w_load[s+1];
    end
  end

  // Stage registers; valid follows every load, payload only loads with a real op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      r_c <= '0;
      for (int unsigned s = 0; s < NS; s++) begin
        r_a[s]   <= '0;
        r_b[s]   <= '0;
        r_sum[s] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < NS; s++) begin
        if (w_load[s]) begin
          r_v[s] <= w_vin[s];
          if (w_vin[s]) begin
            r_a[s]   <= w_a[s];
            r_b[s]   <= w_b[s];
            r_sum[s] <= w_snext[s];
            r_c[s]   <= w_cnext[s];
          end
        end
      end
    end
  end

`ifdef CSLA_PIPE_OVF_EN
  logic r_ovf;
  logic w_ovf_next;

  // Carry into the MSB is recovered as a^b^sum at that bit
  assign w_ovf_next = w_a[NS-1][WIDTH-1] ^ w_b[NS-1][WIDTH-1]
                    ^ w_snext[NS-1][WIDTH-1] ^ w_cnext[NS-1];

  // Overflow flag shares the last stage's load and hold behaviour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_load[NS-1] && w_vin[NS-1]) begin
      r_ovf <= w_ovf_next;
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.in_ready  = w_load[0];
  assign bus.out_valid = r_v[NS-1];
  assign bus.sum       = r_sum[NS-1];
  assign bus.cout      = r_c[NS-1];

endmodule

// File: tb/tb_csla_pipe.sv
// tb_csla_pipe: randomized and directed checks of csla_pipe against an arithmetic model.
// Build with CSLA_PIPE_OVF_EN defined to also check the overflow output.
module tb_csla_pipe;
  import csla_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned NS = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
  } op_t;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  csla_pipe_if #(.WIDTH(W)) bus ();

  csla_pipe #(.WIDTH(W), .BLOCK(4), .GPS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  op_t  pend_q[$];
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_acc   = 0;
  int   n_out   = 0;
  bit   lat_chk, rdy_chk, gaps, rand_ready, stall_prev;
  logic [31:0] held_sum;
  logic        held_cout;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, signed range check for overflow
  function automatic exp_t model(input op_t op);
    exp_t            e;
    longint unsigned ua, ub, r;
    longint          sa, sb, sr;
    ua = {32'd0, op.a};
    ub = {32'd0, op.b};
    sa = longint'($signed(op.a));
    sb = longint'($signed(op.b));
    if (op.sub == OP_SUB) begin
      r      = ua - ub;
      e.cout = (ua >= ub);
      sr     = sa - sb;
    end else begin
      r      = ua + ub + (op.cin ? 64'd1 : 64'd0);
      e.cout = r[32];
      sr     = sa + sb + (op.cin ? 64'sd1 : 64'sd0);
    end
    e.sum     = r[31:0];
    e.ovf     = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.acc_cyc = 0;
    return e;
  endfunction

  function automatic op_t rand_op();
    op_t op;
    op.a   = $urandom();
    op.b   = $urandom();
    op.cin = 1'($urandom_range(1));
    op.sub = 1'($urandom_range(1));
    if ($urandom_range(3) == 0) op.a = 32'hFFFF_FFFF;
    if ($urandom_range(3) == 0) op.b = op.a;
    return op;
  endfunction

  function automatic op_t mk(input logic [31:0] a, input logic [31:0] b,
                             input logic cin, input logic sub);
    op_t op;
    op.a = a; op.b = b; op.cin = cin; op.sub = sub;
    return op;
  endfunction

  // One clock: drive, sample at negedge, score transfers, advance past the edge
  task automatic step();
    op_t  op;
    exp_t e;
    if (pend_q.size() > 0 && !(gaps && $urandom_range(3) == 0)) begin
      op           = pend_q[0];
      bus.in_valid = 1'b1;
    end else begin
      op           = rand_op();
      bus.in_valid = 1'b0;
    end
    bus.a   = op.a;
    bus.b   = op.b;
    bus.cin = op.cin;
    bus.sub = op.sub;
    if (rand_ready) bus.out_ready = 1'($urandom_range(1));
    @(negedge clk);
    if (rdy_chk) chk("in_ready_stream", 64'(bus.in_ready), 64'd1);
    if (bus.out_valid && bus.out_ready) begin
      stall_prev = 1'b0;
      if (exp_q.size() == 0) begin
        chk("spurious_out", 64'(bus.out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sum", 64'(bus.sum), 64'(e.sum));
        chk("cout", 64'(bus.cout), 64'(e.cout));
`ifdef CSLA_PIPE_OVF_EN
        chk("ovf", 64'(bus.ovf), 64'(e.ovf));
`endif
        if (lat_chk) chk("latency", 64'(cyc - e.acc_cyc), 64'(NS));
        n_out++;
      end
    end else if (bus.out_valid) begin
      if (stall_prev) begin
        chk("hold_sum", 64'(bus.sum), 64'(held_sum));
        chk("hold_cout", 64'(bus.cout), 64'(held_cout));
      end
      stall_prev = 1'b1;
      held_sum   = bus.sum;
      held_cout  = bus.cout;
    end else begin
      stall_prev = 1'b0;
    end
    if (bus.in_valid && bus.in_ready) begin
      e         = model(op);
      e.acc_cyc = cyc;
      exp_q.push_back(e);
      void'(pend_q.pop_front());
      n_acc++;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_left", 64'(pend_q.size() + exp_q.size()), 64'd0);
  endtask

  initial begin
    int n0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    lat_chk = 0; rdy_chk = 0; gaps = 0; rand_ready = 0; stall_prev = 0;
    held_sum = '0; held_cout = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_sum", 64'(bus.sum), 64'd0);
    chk("rst_cout", 64'(bus.cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", 64'(bus.in_ready), 64'd1);

    // Directed carry-chain, subtract and overflow cases at full throughput
    lat_chk = 1;
    pend_q.push_back(mk(32'hFFFF_FFFF, 32'h0, 1'b1, OP_ADD));
    pend_q.push_back(mk(32'h0000_000F, 32'h1, 1'b0, OP_ADD));
    pend_q.push_back(mk(32'd5, 32'd7, 1'b0, OP_SUB));
    pend_q.push_back(mk(32'd7, 32'd5, 1'b0, OP_SUB));
    pend_q.push_back(mk(32'd7, 32'd5, 1'b1, OP_SUB));
`ifdef CSLA_PIPE_OVF_EN
    pend_q.push_back(mk(32'h7FFF_FFFF, 32'h1, 1'b0, OP_ADD));
    pend_q.push_back(mk(32'h8000_0000, 32'h1, 1'b0, OP_SUB));
    pend_q.push_back(mk(32'd3, 32'd4, 1'b0, OP_ADD));
`endif
    drain(50);

    // Streaming: 8 back-to-back random ops, ready held high
    for (int i = 0; i < 8; i++) pend_q.push_back(rand_op());
    n0      = n_out;
    rdy_chk = 1;
    repeat (8) step();
    rdy_chk = 0;
    drain(50);
    chk("stream_count", 64'(n_out - n0), 64'd8);

    // Backpressure: only NS ops fit while the consumer stalls
    lat_chk       = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) pend_q.push_back(rand_op());
    n0 = n_acc;
    repeat (8) step();
    chk("bp_accepted", 64'(n_acc - n0), 64'(NS));
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    n0            = n_out;
    bus.out_ready = 1'b1;
    drain(50);
    chk("bp_delivered", 64'(n_out - n0), 64'd6);

    // Asynchronous reset with ops in flight
    bus.out_ready = 1'b0;
    pend_q.push_back(mk(32'd1, 32'd1, 1'b0, OP_ADD));
    pend_q.push_back(rand_op());
    pend_q.push_back(rand_op());
    repeat (6) step();
    chk("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_sum", 64'(bus.sum), 64'd0);
    chk("async_rst_cout", 64'(bus.cout), 64'd0);
`ifdef CSLA_PIPE_OVF_EN
    chk("async_rst_ovf", 64'(bus.ovf), 64'd0);
`endif
    exp_q.delete();
    pend_q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    chk("in_ready_after_async", 64'(bus.in_ready), 64'd1);
    repeat (10) step();

    // Random traffic with bubbles and random backpressure
    gaps       = 1;
    rand_ready = 1;
    for (int i = 0; i < 40; i++) pend_q.push_back(rand_op());
    n0 = n_out;
    drain(2000);
    chk("random_count", 64'(n_out - n0), 64'd40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
